// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/register.sv
// Generic holding register with load enable and synchronous clear.
module register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (sync_reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_reset,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] count_q, count_d;

  assign bit_end = (count_q == CntMax);

  always_comb begin
    count_d = count_q;
    if (sync_reset || bit_end) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start / data (LSB first) / [parity] / stop, BAUD_DIV clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned BAUD_DIV    = 434
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_start,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_serial
);

  localparam int unsigned IdxW = $clog2(WORD_LENGTH + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORD_LENGTH - 1);

  if (BAUD_DIV < 2) begin : gen_bad_baud_div
    $error("uart_tx_ctrl: BAUD_DIV must be at least 2");
  end

  tx_state_t             state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;
  logic                  baud_sync_reset;
  logic [WORD_LENGTH-1:0] holding;
  logic [WORD_LENGTH-1:0] holding_shifted;

  assign accept = (state_q == IDLE) && tx_start;

  register #(
    .WIDTH(WORD_LENGTH)
  ) u_holding (
    .clk       (clk),
    .reset     (reset),
    .enable    (accept),
    .sync_reset(1'b0),
    .d         (tx_data),
    .q         (holding)
  );

  // Counter is parked in IDLE and restarted on every state change so each bit starts at 0.
  assign baud_sync_reset = (state_q == IDLE) || (state_d != state_q);

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk       (clk),
    .reset     (reset),
    .sync_reset(baud_sync_reset),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign holding_shifted = holding >> idx_q;

  always_comb begin
    tx_serial = LINE_IDLE;
    unique case (state_q)
      START:   tx_serial = START_BIT;
      DATA:    tx_serial = holding_shifted[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_serial = ^holding;
`endif
      STOP:    tx_serial = STOP_BIT;
      default: tx_serial = LINE_IDLE;
    endcase
  end

  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (WORD_LENGTH=8, BAUD_DIV=4); parity case under UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

  localparam int W = 8;
  localparam int B = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (2 + W + P) * B;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tx_start = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_busy;
  logic         tx_done;
  logic         tx_serial;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .WORD_LENGTH(W),
    .BAUD_DIV   (B)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_serial(tx_serial)
  );

  // Expected {busy, done, serial} in cycle k after the accepting edge (cycle 1 = first start cycle).
  function automatic logic [2:0] exp_at(input logic [W-1:0] d, input int k);
    int b;
    if (k < 1 || k > FRAME + 1) return 3'b001;
    if (k == FRAME + 1) return 3'b011;
    b = (k - 1) / B;
    if (b == 0) return 3'b100;
    if (b <= W) return {2'b10, d[b-1]};
    if (P == 1 && b == W + 1) return {2'b10, ^d};
    return 3'b101;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), {tx_busy, tx_done, tx_serial}, 3'b001);
    end
  endtask

  // Request is sampled by the following rising edge (edge 0).
  task automatic launch(input logic [W-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [W-1:0] d, input int glitch);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      tx_start = (k == glitch);
      if (k == glitch) tx_data = 8'hFF;
      check($sformatf("%s[%0d]", tag, k), {tx_busy, tx_done, tx_serial}, exp_at(d, k));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {tx_busy, tx_done, tx_serial}, 3'b001);
    reset = 1'b1;
    idle_cycles(20, "idle");

    launch(8'hA5);
    frame("a5", 8'hA5, 0);
    idle_cycles(5, "a5_after");

    // Start request mid-frame must be ignored entirely.
    launch(8'hA5);
    frame("a5_ign", 8'hA5, 10);
    idle_cycles(FRAME, "no_second");

`ifdef UART_TX_PARITY_EN
    launch(8'h07);
    frame("par07", 8'h07, 0);
    idle_cycles(3, "par_after");
`endif

    // Reset during data bit 3 (cycle 18).
    launch(8'h3C);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      check($sformatf("pre_rst[%0d]", k), {tx_busy, tx_done, tx_serial}, exp_at(8'h3C, k));
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_abort", {tx_busy, tx_done, tx_serial}, 3'b001);
    idle_cycles(2, "in_rst");
    reset = 1'b1;
    idle_cycles(FRAME + 2, "post_rst");
    launch(8'h3C);
    frame("3c", 8'h3C, 0);
    idle_cycles(3, "3c_after");

    // Held request: second frame starts right after the tx_done cycle.
    launch(8'h55);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      if (k == 20) tx_data = 8'hAA;
      check($sformatf("b2b_55[%0d]", k), {tx_busy, tx_done, tx_serial}, exp_at(8'h55, k));
    end
    for (int j = 1; j <= FRAME + 1; j++) begin
      @(negedge clk);
      if (j == 1) tx_start = 1'b0;
      check($sformatf("b2b_aa[%0d]", j), {tx_busy, tx_done, tx_serial}, exp_at(8'hAA, j));
    end
    idle_cycles(5, "b2b_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
